axis_sample_unpacker: RTL and testbench
=======================================

Name: axis_sample_unpacker

Overview:
- Receive-side counterpart of the DDS sample packer.
- Reads 32-bit sign-extended sample words from the FIFO master port and recovers 20-bit signed sine samples.
- Checks that each word is a legal sign extension; if not, saturates the sample and counts the error.
- Presents samples on a 24-bit AXI-Stream master toward the DAC path through a full-throughput registered skid stage, and reports overflow and starvation statistics.

Parameters:
- IN_W, 32: input word width from FIFO.
- SAMPLE_W, 20: signed sample width carried in IN_W[SAMPLE_W-1:0].
- OUT_W, 24: output width; sample in [SAMPLE_W-1:0], sign-extended above.
- CNT_W, 16: width of the status counters.

Ports:
- aclk  in  1  single clock.
- areset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  IN_W  packed sample word from FIFO.
- s_axis_tvalid  in  1  FIFO word valid.
- s_axis_tready  out  1  block accepts word.
- m_axis_tdata  out  OUT_W  unpacked sample.
- m_axis_tvalid  out  1  output sample valid.
- m_axis_tready  in  1  downstream ready.
- ovf_count  out  CNT_W  saturating count of malformed (saturated) words.
- ovf_sticky  out  1  set on first malformed word; cleared only by reset.
- underrun_count  out  CNT_W  saturating count of starved cycles.
- sample_count  out  CNT_W  wrapping count of output transfers.

Behaviour:
- Reset (areset=1 at rising aclk) clears all state: m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=0, all counters 0, ovf_sticky=0, skid empty, armed=0. Reset mid-transfer discards held data with no partial output.
- Cycle after reset release: s_axis_tready=1.
- Input transfer occurs when s_axis_tvalid && s_axis_tready. Output transfer occurs when m_axis_tvalid && m_axis_tready.
- Unpack (combinational on the input word w):
  - legal when w[IN_W-1:SAMPLE_W-1] are all equal.
  - legal: sample=w[SAMPLE_W-1:0].
  - illegal and w[IN_W-1]=0: sample=+2^(SAMPLE_W-1)-1 (0x7FFFF).
  - illegal and w[IN_W-1]=1: sample=-2^(SAMPLE_W-1) (0x80000).
  - out word = {(OUT_W-SAMPLE_W) copies of sample MSB, sample}.
- Storage is two registers: main (drives m_axis_*) and skid. s_axis_tready is registered and equals !skid_valid.
  - Input transfer with main empty, or main draining this cycle: data goes to main.
  - Input transfer with main full and not draining: data goes to skid, and tready drops next cycle.
  - Output transfer with skid full: skid moves to main, and tready rises next cycle.
- Latency: input accepted at edge N appears on m_axis at edge N+1. Sustained throughput is 1 word/cycle when m_axis_tready=1.
- m_axis_tdata and m_axis_tvalid are stable while tvalid=1 and tready=0.
- ovf_count increments by 1 per accepted illegal word and holds at all-ones. ovf_sticky is set on the same edge.
- armed is set on the first output transfer after reset. While armed, each cycle with m_axis_tready=1 and m_axis_tvalid=0 increments underrun_count, which holds at all-ones.
- sample_count increments on each output transfer and wraps from all-ones to 0.
- Simultaneous input and output transfer with main full and skid empty: main is reloaded with the new data; tvalid stays 1 and the skid is untouched.
- No bubbles and no loss under any ready/valid pattern. Words are never reordered or duplicated.

Test Plan:
- Reset, then stream 0x00000001, 0xFFFFFFFF, 0x0007FFFF, 0xFFF80000 with m_axis_tready=1 -> outputs 0x000001, 0xFFFFFF, 0x07FFFF, 0xF80000, each 1 cycle after accept; ovf_count=0; sample_count=4.
- Send 0x00080000 and 0x80000000 -> outputs 0x07FFFF and 0xF80000; ovf_count=2; ovf_sticky=1.
- Continuous valid input; hold m_axis_tready=0 for 3 cycles -> s_axis_tready drops after 2 accepts and main holds its first word steady; after release, all words emerge in order with no gap.
- Random valid/ready (50% each) over 10000 words against a scoreboard -> exact order match; sample_count=10000 mod 2^16.
- After the first output, starve input for 5 cycles with m_axis_tready=1 -> underrun_count=5. Before the first output, idle cycles -> underrun_count stays 0.
- Assert areset while main and skid are both full -> next cycle m_axis_tvalid=0 and all counters 0; after release, a new word passes with latency 1.

Source files
------------

// File: rtl/axis_sample_unpacker_if.sv
// axis_sample_unpacker_if: AXI-Stream data/valid/ready bundle
interface axis_sample_unpacker_if #(parameter int W = 32);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  modport master(output tdata, tvalid, input tready);
  modport slave(input tdata, tvalid, output tready);
endinterface

// File: rtl/axis_sample_unpacker.sv
// axis_sample_unpacker: sign-extension check, saturation and skid-buffered AXIS output
module axis_sample_unpacker #(
  parameter int IN_W     = 32,
  parameter int SAMPLE_W = 20,
  parameter int OUT_W    = 24,
  parameter int CNT_W    = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  axis_sample_unpacker_if.slave  s_axis,
  axis_sample_unpacker_if.master m_axis,
  output logic [CNT_W-1:0]     ovf_count,
  output logic                 ovf_sticky,
  output logic [CNT_W-1:0]     underrun_count,
  output logic [CNT_W-1:0]     sample_count
);
  logic [IN_W-SAMPLE_W:0] hi;
  logic                   legal;
  logic [SAMPLE_W-1:0]    sample;
  logic [OUT_W-1:0]       unp, main_data, skid_data;
  logic                   main_valid, skid_valid, rdy, armed;
  logic                   in_xfer, out_xfer, skid_load, skid_next;
  assign hi        = s_axis.tdata[IN_W-1:SAMPLE_W-1];
  assign legal     = (hi == '0) || (hi == '1);
  assign sample    = legal ? s_axis.tdata[SAMPLE_W-1:0]
                   : s_axis.tdata[IN_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                   : {1'b0, {(SAMPLE_W-1){1'b1}}};
  assign unp       = {{(OUT_W-SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
  assign in_xfer   = s_axis.tvalid && rdy;
  assign out_xfer  = main_valid && m_axis.tready;
  // skid only fills when main is occupied and cannot drain this cycle
  assign skid_load = in_xfer && main_valid && !m_axis.tready;
  assign skid_next = (skid_valid || skid_load) && !m_axis.tready;
  assign s_axis.tready = rdy;
  assign m_axis.tdata  = main_data;
  assign m_axis.tvalid = main_valid;
  always_ff @(posedge aclk) begin
    if (areset) begin
      main_data      <= '0;
      main_valid     <= 1'b0;
      skid_data      <= '0;
      skid_valid     <= 1'b0;
      rdy            <= 1'b0;
      armed          <= 1'b0;
      ovf_count      <= '0;
      ovf_sticky     <= 1'b0;
      underrun_count <= '0;
      sample_count   <= '0;
    end else begin
      if (!main_valid || m_axis.tready) begin
        main_valid <= skid_valid || in_xfer;
        main_data  <= skid_valid ? skid_data : in_xfer ? unp : main_data;
      end
      if (skid_load) skid_data <= unp;
      skid_valid <= skid_next;
      rdy        <= !skid_next;
      armed      <= armed || out_xfer;
      if (in_xfer && !legal) begin
        ovf_sticky <= 1'b1;
        if (ovf_count != '1) ovf_count <= ovf_count + CNT_W'(1);
      end
      if (armed && m_axis.tready && !main_valid && underrun_count != '1)
        underrun_count <= underrun_count + CNT_W'(1);
      sample_count <= sample_count + CNT_W'(out_xfer);
    end
  end
endmodule

// File: tb/tb_axis_sample_unpacker.sv
// tb_axis_sample_unpacker: directed vectors plus randomized scoreboard run
module tb_axis_sample_unpacker;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [15:0] ovf_count, underrun_count, sample_count;
  logic        ovf_sticky;
  int          total = 0, bad = 0;
  logic [23:0] q[$];
  logic        pv = 1'b0, pr = 1'b0;
  logic [23:0] pd = '0;
  axis_sample_unpacker_if #(.W(32)) s_if();
  axis_sample_unpacker_if #(.W(24)) m_if();
  axis_sample_unpacker dut (
    .aclk(aclk), .areset(areset), .s_axis(s_if), .m_axis(m_if),
    .ovf_count(ovf_count), .ovf_sticky(ovf_sticky),
    .underrun_count(underrun_count), .sample_count(sample_count)
  );
  always #5 aclk = ~aclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [23:0] exp_of(input logic [31:0] w);
    longint s;
    s = longint'($signed(w));
    if (s > 524287) s = 524287;
    if (s < -524288) s = -524288;
    return s[23:0];
  endfunction
  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    r = $urandom;
    return ($urandom_range(0, 3) == 0) ? r : {{12{r[19]}}, r[19:0]};
  endfunction
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask
  task automatic apply_reset();
    areset = 1'b1;
    s_if.tvalid = 1'b0;
    repeat (2) tick();
    areset = 1'b0;
    tick();
  endtask
  // scoreboard and stability monitor, sampled mid-cycle
  initial forever begin
    logic [23:0] e;
    @(negedge aclk);
    if (areset) begin
      q.delete();
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", 32'(m_if.tvalid), 32'd1);
        chk("hold_data", 32'(m_if.tdata), 32'(pd));
      end
      if (s_if.tvalid && s_if.tready) q.push_back(exp_of(s_if.tdata));
      if (m_if.tvalid && m_if.tready) begin
        e = 'x;
        if (q.size() != 0) e = q.pop_front();
        chk("order", 32'(m_if.tdata), 32'(e));
      end
      pv = m_if.tvalid;
      pr = m_if.tready;
      pd = m_if.tdata;
    end
  end
  initial begin
    logic [31:0] dw[6];
    logic [23:0] de[6];
    logic        acc;
    int          n, acc_n, offered, cyc;
    dw = '{32'h00000001, 32'hFFFFFFFF, 32'h0007FFFF, 32'hFFF80000, 32'h00080000, 32'h80000000};
    de = '{24'h000001, 24'hFFFFFF, 24'h07FFFF, 24'hF80000, 24'h07FFFF, 24'hF80000};
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b1;
    repeat (3) tick();
    chk("rst_mvalid", 32'(m_if.tvalid), 0);
    chk("rst_mdata", 32'(m_if.tdata), 0);
    chk("rst_sready", 32'(s_if.tready), 0);
    chk("rst_samples", 32'(sample_count), 0);
    areset = 1'b0;
    tick();
    chk("sready_after_rst", 32'(s_if.tready), 1);
    repeat (4) tick();
    chk("underrun_unarmed", 32'(underrun_count), 0);
    for (int i = 0; i < 6; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = dw[i];
      tick();
      chk("lat_data", 32'(m_if.tdata), 32'(de[i]));
      chk("lat_valid", 32'(m_if.tvalid), 1);
      if (i == 3) begin
        s_if.tvalid = 1'b0;
        tick();
        chk("samples4", 32'(sample_count), 4);
        chk("ovf0", 32'(ovf_count), 0);
        chk("sticky0", 32'(ovf_sticky), 0);
      end
    end
    s_if.tvalid = 1'b0;
    tick();
    chk("ovf2", 32'(ovf_count), 2);
    chk("sticky1", 32'(ovf_sticky), 1);
    chk("samples6", 32'(sample_count), 6);
    apply_reset();
    repeat (4) tick();
    chk("underrun_idle", 32'(underrun_count), 0);
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'h00000123;
    tick();
    s_if.tvalid = 1'b0;
    tick();
    chk("underrun_first", 32'(underrun_count), 0);
    repeat (5) tick();
    chk("underrun5", 32'(underrun_count), 5);
    n = 0;
    m_if.tready = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'h100;
    repeat (3) begin
      acc = s_if.tvalid && s_if.tready;
      tick();
      if (acc) begin n++; s_if.tdata = 32'h100 + n; end
    end
    chk("stall_accepts", n, 2);
    chk("stall_sready", 32'(s_if.tready), 0);
    chk("stall_data", 32'(m_if.tdata), 32'h000100);
    m_if.tready = 1'b1;
    repeat (6) begin
      acc = s_if.tvalid && s_if.tready;
      tick();
      if (acc) begin n++; s_if.tdata = 32'h100 + n; end
      chk("no_gap", 32'(m_if.tvalid), 1);
    end
    s_if.tvalid = 1'b0;
    repeat (4) tick();
    apply_reset();
    acc_n = 0; offered = 0; cyc = 0;
    while (acc_n < 10000 && cyc < 60000) begin
      m_if.tready = 1'($urandom_range(0, 1));
      if (!s_if.tvalid && offered < 10000 && $urandom_range(0, 1) == 1) begin
        s_if.tvalid = 1'b1;
        s_if.tdata  = rand_word();
        offered++;
      end
      acc = s_if.tvalid && s_if.tready;
      tick();
      cyc++;
      if (acc) begin acc_n++; s_if.tvalid = 1'b0; end
    end
    chk("rand_accepted", acc_n, 10000);
    m_if.tready = 1'b1;
    cyc = 0;
    while ((q.size() != 0 || m_if.tvalid) && cyc < 20) begin tick(); cyc++; end
    chk("rand_drained", q.size(), 0);
    chk("rand_samples", 32'(sample_count), 32'd10000);
    m_if.tready = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'h80000000;
    tick();
    s_if.tdata  = 32'h00080000;
    tick();
    chk("full_sready", 32'(s_if.tready), 0);
    areset = 1'b1;
    s_if.tvalid = 1'b0;
    tick();
    chk("mid_rst_mvalid", 32'(m_if.tvalid), 0);
    chk("mid_rst_mdata", 32'(m_if.tdata), 0);
    chk("mid_rst_sready", 32'(s_if.tready), 0);
    chk("mid_rst_ovf", 32'(ovf_count), 0);
    chk("mid_rst_sticky", 32'(ovf_sticky), 0);
    chk("mid_rst_underrun", 32'(underrun_count), 0);
    chk("mid_rst_samples", 32'(sample_count), 0);
    areset = 1'b0;
    m_if.tready = 1'b1;
    tick();
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'hFFFFFFFE;
    tick();
    s_if.tvalid = 1'b0;
    chk("post_rst_data", 32'(m_if.tdata), 32'h00FFFFFE);
    chk("post_rst_valid", 32'(m_if.tvalid), 1);
    repeat (3) tick();
    chk("post_rst_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
